systolic_output_drain: RTL and testbench

Collects the output-stationary result grid from the systolic array once every PE reports valid, snapshots it, and streams it out one row per beat over a valid/ready interface toward the memory writer. It sits between the array's `output_o`/`output_valid_o` grid and the result write path. It decouples array completion from downstream backpressure, so the array can be reset and restarted as soon as the snapshot is taken.

---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_output_drain.sv | 93 +++++++++
 tb/tb_systolic_output_drain.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array datapath blocks.
package systolic_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } drain_state_e;

  // Index width that never collapses to zero bits for tiny dimensions.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/systolic_output_drain.sv
// Snapshots the systolic result grid once every PE is valid, then streams it out
// one row per beat over valid/ready so the array can restart immediately.
module systolic_output_drain
  import systolic_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned NUM_ROWS     = 16,
  parameter int unsigned NUM_COLS     = 16
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUTPUT_WIDTH-1:0]     array_output_i,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                       array_valid_i,
  output logic                                                    capture_ready_o,
  output logic [NUM_COLS-1:0][OUTPUT_WIDTH-1:0]                   row_data_o,
  output logic                                                    row_valid_o,
  input  logic                                                    row_ready_i,
  output logic [clog2_min1(NUM_ROWS)-1:0]                         row_idx_o,
  output logic                                                    row_last_o,
  output logic                                                    drain_done_o,
  output logic                                                    overrun_o
);

  localparam int unsigned IdxW = clog2_min1(NUM_ROWS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ROWS - 1);

  drain_state_e state_q;
  logic [IdxW-1:0] row_idx_q;
  logic all_valid, all_valid_q, capture;
  logic capture_ready_q, row_valid_q, drain_done_q, overrun_q;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUTPUT_WIDTH-1:0] snapshot_q;

  assign all_valid = &array_valid_i;
  // Only the rising edge of all-valid counts, so a held grid is taken once.
  assign capture   = all_valid && !all_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      row_idx_q       <= '0;
      all_valid_q     <= 1'b0;
      capture_ready_q <= 1'b1;
      row_valid_q     <= 1'b0;
      drain_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      all_valid_q  <= all_valid;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            state_q         <= StStream;
            row_idx_q       <= '0;
            capture_ready_q <= 1'b0;
            row_valid_q     <= 1'b1;
          end
        end
        StStream: begin
          if (capture) overrun_q <= 1'b1;
          if (row_ready_i) begin
            if (row_idx_q == LastIdx) begin
              state_q         <= StIdle;
              row_idx_q       <= '0;
              capture_ready_q <= 1'b1;
              row_valid_q     <= 1'b0;
              drain_done_q    <= 1'b1;
            end else begin
              row_idx_q <= row_idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Snapshot needs no reset; it is only observed after an accepted capture.
  always_ff @(posedge clk_i) begin
    if (state_q == StIdle && capture) snapshot_q <= array_output_i;
  end

  always_comb begin
    row_data_o      = snapshot_q[row_idx_q];
    row_valid_o     = row_valid_q;
    row_idx_o       = row_idx_q;
    row_last_o      = row_valid_q && (row_idx_q == LastIdx);
    capture_ready_o = capture_ready_q;
    drain_done_o    = drain_done_q;
    overrun_o       = overrun_q;
  end

endmodule

// File: tb/tb_systolic_output_drain.sv
// Scoreboard bench for systolic_output_drain with a 4x4 grid of 32-bit results.
module tb_systolic_output_drain;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int W  = 32;

  typedef logic [NC-1:0][W-1:0] row_t;
  typedef logic [NR-1:0][NC-1:0][W-1:0] grid_t;

  logic clk = 1'b0;
  logic rst;
  grid_t grid;
  logic [NR-1:0][NC-1:0] valid;
  logic capture_ready;
  row_t row_data;
  logic row_valid;
  logic row_ready;
  logic [1:0] row_idx;
  logic row_last;
  logic drain_done;
  logic overrun;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int dd_cnt = 0;

  row_t exp_q[$];
  int   exp_idx_q[$];

  systolic_output_drain #(
    .OUTPUT_WIDTH(W),
    .NUM_ROWS    (NR),
    .NUM_COLS    (NC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .array_output_i (grid),
    .array_valid_i  (valid),
    .capture_ready_o(capture_ready),
    .row_data_o     (row_data),
    .row_valid_o    (row_valid),
    .row_ready_i    (row_ready),
    .row_idx_o      (row_idx),
    .row_last_o     (row_last),
    .drain_done_o   (drain_done),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (drain_done) dd_cnt++;
  end

  function automatic grid_t make_grid(input int base);
    grid_t g;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        g[r][c] = W'(base + 16 * r + c);
    return g;
  endfunction

  // Drive a new grid with all valids high and record the rows it should produce.
  task automatic drive_capture(input int base);
    grid  = make_grid(base);
    valid = '1;
    for (int r = 0; r < NR; r++) begin
      exp_q.push_back(grid[r]);
      exp_idx_q.push_back(r);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Scoreboard consumer: pops an expected row on every handshake, then checks drain_done.
  task automatic consume(input bit bp, output int first_cyc, output int last_cyc);
    int cyc = 0;
    bit held = 1'b0;
    row_t prev_data;
    logic [1:0] prev_idx;
    row_t exp_r;
    int exp_i;
    first_cyc = -1;
    last_cyc  = -1;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        checks++;
        if (row_data !== prev_data || row_idx !== prev_idx) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d got idx=%0d data=%h want idx=%0d data=%h",
                   cyc, row_idx, row_data, prev_idx, prev_data);
        end
      end
      row_ready = bp ? (cyc % 3 == 1) : 1'b1;
      if (row_valid && row_ready) begin
        exp_r = exp_q.pop_front();
        exp_i = exp_idx_q.pop_front();
        checks++;
        if (row_data !== exp_r) begin
          errors++;
          $display("FAIL row_data idx=%0d got %h want %h", exp_i, row_data, exp_r);
        end
        checks++;
        if (row_idx !== 2'(exp_i)) begin
          errors++;
          $display("FAIL row_idx got %0d want %0d", row_idx, exp_i);
        end
        checks++;
        if (row_last !== (exp_i == NR - 1)) begin
          errors++;
          $display("FAIL row_last idx=%0d got %b want %b", exp_i, row_last, exp_i == NR - 1);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        held = 1'b0;
      end else begin
        held      = row_valid;
        prev_data = row_data;
        prev_idx  = row_idx;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d rows left want 0", exp_q.size());
      exp_q.delete();
      exp_idx_q.delete();
    end
    @(negedge clk);
    checks++;
    if (drain_done !== 1'b1 || row_valid !== 1'b0 || capture_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_done got done=%b valid=%b cap_ready=%b want 1 0 1",
               drain_done, row_valid, capture_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '0; grid = '0; row_ready = 1'b0;
    #1;
    checks++;
    if (capture_ready !== 1'b1 || row_valid !== 1'b0 || row_last !== 1'b0 ||
        drain_done !== 1'b0 || overrun !== 1'b0 || row_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got cr=%b v=%b last=%b dd=%b ov=%b idx=%0d want 1 0 0 0 0 0",
               capture_ready, row_valid, row_last, drain_done, overrun, row_idx);
    end
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    int f, l;
    drive_capture(0);
    row_ready = 1'b1;
    consume(1'b0, f, l);
    checks++;
    if (f != 1 || l != NR) begin
      errors++;
      $display("FAIL basic_timing got first=%0d last=%0d want 1 %0d", f, l, NR);
    end
  endtask

  task automatic test_held_overrun();
    int f, l, ov0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (row_valid !== 1'b0) begin
        errors++;
        $display("FAIL held_no_recapture cyc=%0d got valid=%b want 0", i, row_valid);
      end
    end
    valid = '0;
    @(negedge clk);
    row_ready = 1'b0;
    drive_capture(100);
    @(negedge clk);
    valid = '0;
    ov0 = ov_cnt;
    @(negedge clk);
    grid  = make_grid(200);
    valid = '1;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse got %b want 1", overrun);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || row_idx !== 2'd0) begin
      errors++;
      $display("FAIL overrun_single got ov=%b idx=%0d want 0 0", overrun, row_idx);
    end
    consume(1'b0, f, l);
    checks++;
    if (ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL overrun_count got %0d want 1", ov_cnt - ov0);
    end
    valid = '0;
    idle_cycles(2);
  endtask

  task automatic test_partial_valid();
    int f, l;
    grid  = make_grid(50);
    valid = '1;
    valid[NR-1][NC-1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (row_valid !== 1'b0 || capture_ready !== 1'b1) begin
        errors++;
        $display("FAIL partial_no_capture cyc=%0d got valid=%b cr=%b want 0 1",
                 i, row_valid, capture_ready);
      end
    end
    drive_capture(50);
    consume(1'b0, f, l);
    checks++;
    if (f != 1) begin
      errors++;
      $display("FAIL partial_capture_cycle got %0d want 1", f);
    end
    valid = '0;
    idle_cycles(2);
  endtask

  task automatic test_backpressure();
    int f, l;
    drive_capture(300);
    consume(1'b1, f, l);
    checks++;
    if (f != 1 || l != 10) begin
      errors++;
      $display("FAIL bp_timing got first=%0d last=%0d want 1 10", f, l);
    end
    valid = '0;
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    int f, l, ov0;
    ov0 = ov_cnt;
    row_ready = 1'b0;
    drive_capture(400);
    @(negedge clk);
    valid = '0;
    consume(1'b0, f, l);
    drive_capture(500);
    consume(1'b0, f, l);
    checks++;
    if (f != 1) begin
      errors++;
      $display("FAIL b2b_first_cycle got %0d want 1", f);
    end
    checks++;
    if (ov_cnt != ov0) begin
      errors++;
      $display("FAIL b2b_overrun got %0d pulses want 0", ov_cnt - ov0);
    end
    valid = '0;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_drain();
    int f, l, dd0;
    row_t exp_r;
    int exp_i;
    drive_capture(600);
    row_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp_r = exp_q.pop_front();
      exp_i = exp_idx_q.pop_front();
      checks++;
      if (row_valid !== 1'b1 || row_data !== exp_r || row_idx !== 2'(exp_i)) begin
        errors++;
        $display("FAIL pre_reset_row got v=%b idx=%0d data=%h want 1 %0d %h",
                 row_valid, row_idx, row_data, exp_i, exp_r);
      end
    end
    @(negedge clk);
    dd0 = dd_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (row_valid !== 1'b0 || capture_ready !== 1'b1 || row_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_abort got v=%b cr=%b idx=%0d want 0 1 0",
               row_valid, capture_ready, row_idx);
    end
    exp_q.delete();
    exp_idx_q.delete();
    valid = '0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);
    checks++;
    if (dd_cnt != dd0 || row_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got dd=%0d v=%b want 0 0", dd_cnt - dd0, row_valid);
    end
    drive_capture(700);
    consume(1'b0, f, l);
    checks++;
    if (f != 1) begin
      errors++;
      $display("FAIL post_reset_first got %0d want 1", f);
    end
    valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_overrun();
    test_partial_valid();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    idle_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
